cache_refill: RTL
=================

CACHE_REFILL -- requirements
Module: cache_refill

Interface
Parameters come from cache_pkg (SetWidth, TagWidth, Associativity, WayWidth, DataWidth, block_info_t, block_data_t); there are no local parameters.
REQ-001: Associativity SHALL be >= 2 and a power of two; WayWidth SHALL equal $clog2(Associativity).
REQ-002: Ports, clock and reset first (name  direction  width  meaning):
- clk_i  in  1  single clock; all state changes on its rising edge
- rst_ni  in  1  synchronous reset, active low
- req_valid_i  in  1  a lookup result is offered
- req_ready_o  out  1  the block accepts the lookup result
- req_set_i  in  SetWidth  set of the lookup
- req_tag_i  in  TagWidth  tag of the lookup
- req_hit_i  in  1  cache read_hit_o for this lookup
- req_info_i  in  block_info_t[Associativity]  current info vector of req_set_i
- mem_req_valid_o  out  1  refill fetch request is valid
- mem_req_ready_i  in  1  memory accepts the fetch
- mem_req_addr_o  out  TagWidth+SetWidth  fetch address {tag, set}
- mem_rsp_valid_i  in  1  refill data is valid
- mem_rsp_ready_o  out  1  the block accepts refill data
- mem_rsp_data_i  in  DataWidth  refill block (block_data_t)
- write_en_o  out  1  cache write strobe (info vector and data written together)
- write_set_o  out  SetWidth  set being written
- write_info_o  out  block_info_t[Associativity]  new info vector for write_set_o
- write_data_way_o  out  WayWidth  victim way
- write_data_o  out  DataWidth  data for the victim way
- done_o  out  1  one-cycle pulse when a request completes
- done_miss_o  out  1  qualifies done_o: 1 = refill performed, 0 = hit
- busy_o  out  1  state is not IDLE

Function
REQ-003: The FSM SHALL have exactly four states: IDLE, MEM_REQ, MEM_WAIT, WRITE.
REQ-004: req_ready_o SHALL be 1 only in IDLE; a request is accepted when req_valid_i & req_ready_o.
REQ-005: An accepted hit SHALL NOT change state; done_o=1 and done_miss_o=0 SHALL be driven in the next cycle.
REQ-006: An accepted miss SHALL register the set, tag and info vector, choose the victim in the same cycle, and move to MEM_REQ.
REQ-007: Victim selection SHALL pick the lowest-index way with valid=0; if every way is valid, it SHALL pick the round-robin pointer of that set.
REQ-008: One WayWidth-bit round-robin pointer per set (2^SetWidth entries) SHALL be kept; the pointer SHALL increment modulo Associativity in WRITE, and only when the victim came from the pointer.
REQ-009: In MEM_REQ, mem_req_valid_o SHALL be 1 and mem_req_addr_o SHALL be {registered tag, registered set}, both held stable until mem_req_ready_i; on handshake the FSM SHALL move to MEM_WAIT.
REQ-010: In MEM_WAIT, mem_rsp_ready_o SHALL be 1; on mem_rsp_valid_i the FSM SHALL register the data and move to WRITE. In every other state mem_rsp_ready_o SHALL be 0.
REQ-011: WRITE SHALL last exactly one cycle and drive:
- write_en_o=1
- write_set_o = registered set
- write_data_way_o = victim
- write_data_o = registered data
- write_info_o = registered info vector with the victim entry replaced by {valid=1, tag=registered tag}, all other entries unchanged
- done_o=1 and done_miss_o=1
The next state SHALL be IDLE.
REQ-012: With zero-wait memory, a miss accepted in cycle 0 SHALL have MEM_REQ in cycle 1, MEM_WAIT in cycle 2 and WRITE in cycle 3.
REQ-013: Outside WRITE, write_en_o SHALL be 0. done_o SHALL be 1 only in the cycles specified in REQ-005 and REQ-011.
REQ-014: A mem_rsp_valid_i arriving outside MEM_WAIT SHALL be ignored.
REQ-015: busy_o SHALL be 1 in MEM_REQ, MEM_WAIT and WRITE.

Reset
REQ-016: When rst_ni=0 at a rising edge, the block SHALL:
- set the state to IDLE
- clear all round-robin pointers to 0
- drive every output to 0, except req_ready_o, which is 1 from the first cycle after reset.
REQ-017: Reset in any state SHALL abandon the in-flight refill with no cache write; a response arriving after reset SHALL be dropped.

Verification (Associativity=4, set 3)
REQ-018: Hit: req_hit_i=1, req_valid_i=1 -> done_o=1 and done_miss_o=0 next cycle; no mem_req_valid_o; write_en_o stays 0.
REQ-019: Miss, ways 0-1 valid, ways 2-3 invalid, tag 0x5 -> mem_req_addr_o={0x5,3}; data 0xA5 -> write_data_way_o=2, write_info_o[2]={1,0x5}, entries 0,1,3 unchanged.
REQ-020: Four misses on set 3 with all ways valid -> victims 0,1,2,3, then 0 (pointer wrap); pointer of set 2 stays 0.
REQ-021: mem_req_ready_i held low for 5 cycles -> mem_req_valid_o and mem_req_addr_o stable for all 5; mem_rsp_valid_i pulsed during MEM_REQ is ignored.
REQ-022: rst_ni=0 during MEM_WAIT -> IDLE next cycle; a response arriving the cycle after is dropped with no write_en_o; pointers read 0.
REQ-023: Zero-wait miss -> write_en_o exactly in cycle 3; req_ready_o=0 in cycles 1-3 and 1 again in cycle 4.

Source files
------------

// File: rtl/cache_pkg.sv
// cache_pkg: geometry and entry types shared by the cache and its refill engine.
//   SetWidth/TagWidth  - index and tag widths of the lookup address
//   Associativity      - ways per set (power of two, >= 2)
//   WayWidth           - $clog2(Associativity), width of a way index
//   DataWidth          - width of one cache block
package cache_pkg;

  localparam int SetWidth      = 3;
  localparam int TagWidth      = 8;
  localparam int Associativity = 4;
  localparam int WayWidth      = $clog2(Associativity);
  localparam int DataWidth     = 8;

  typedef struct packed {
    logic                valid;
    logic [TagWidth-1:0] tag;
  } block_info_t;

  typedef logic [DataWidth-1:0] block_data_t;

endpackage

// File: rtl/cache_refill.sv
// cache_refill: miss handler for a set-associative cache.
// Takes a lookup result; hits complete immediately, misses pick a victim way,
// fetch the block from memory and write the info vector and data back.
// Ports:
//   clk_i, rst_ni                - clock, synchronous active-low reset
//   req_*                        - lookup result handshake (set, tag, hit, info vector)
//   mem_req_*                    - refill fetch request, address {tag, set}
//   mem_rsp_*                    - refill data return
//   write_*                      - one-cycle cache write (info vector + victim data)
//   done_o / done_miss_o         - completion pulse, qualified hit (0) / refill (1)
//   busy_o                       - a refill is in flight
//
// state    | meaning
// IDLE     | ready for a lookup; hits complete here
// MEM_REQ  | fetch request presented to memory
// MEM_WAIT | waiting for refill data
// WRITE    | single-cycle cache write, completion of the miss
module cache_refill
  import cache_pkg::*;
(
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            req_valid_i,
  output logic                            req_ready_o,
  input  logic [SetWidth-1:0]             req_set_i,
  input  logic [TagWidth-1:0]             req_tag_i,
  input  logic                            req_hit_i,
  input  block_info_t [Associativity-1:0] req_info_i,
  output logic                            mem_req_valid_o,
  input  logic                            mem_req_ready_i,
  output logic [TagWidth+SetWidth-1:0]    mem_req_addr_o,
  input  logic                            mem_rsp_valid_i,
  output logic                            mem_rsp_ready_o,
  input  logic [DataWidth-1:0]            mem_rsp_data_i,
  output logic                            write_en_o,
  output logic [SetWidth-1:0]             write_set_o,
  output block_info_t [Associativity-1:0] write_info_o,
  output logic [WayWidth-1:0]             write_data_way_o,
  output logic [DataWidth-1:0]            write_data_o,
  output logic                            done_o,
  output logic                            done_miss_o,
  output logic                            busy_o
);

  typedef enum logic [1:0] {IDLE, MEM_REQ, MEM_WAIT, WRITE} state_e;

  state_e                          state_q;
  logic                            hit_done_q;
  logic [SetWidth-1:0]             set_q;
  logic [TagWidth-1:0]             tag_q;
  block_info_t [Associativity-1:0] info_q;
  block_data_t                     data_q;
  logic [WayWidth-1:0]             victim_q;
  logic                            from_ptr_q;
  logic [WayWidth-1:0]             rr_q [2**SetWidth];

  logic [WayWidth-1:0]             victim_d;
  logic                            from_ptr_d;

  // Lowest-index invalid way wins; the downward loop lets lower indices
  // overwrite higher ones. With no invalid way, fall back to the set's pointer.
  always_comb begin
    victim_d   = rr_q[req_set_i];
    from_ptr_d = 1'b1;
    for (int i = Associativity - 1; i >= 0; i--) begin
      if (!req_info_i[i].valid) begin
        victim_d   = WayWidth'(i);
        from_ptr_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      hit_done_q <= 1'b0;
      set_q      <= '0;
      tag_q      <= '0;
      info_q     <= '0;
      data_q     <= '0;
      victim_q   <= '0;
      from_ptr_q <= 1'b0;
      for (int s = 0; s < 2**SetWidth; s++) begin
        rr_q[s] <= '0;
      end
    end else begin
      hit_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            if (req_hit_i) begin
              hit_done_q <= 1'b1;
            end else begin
              set_q      <= req_set_i;
              tag_q      <= req_tag_i;
              info_q     <= req_info_i;
              victim_q   <= victim_d;
              from_ptr_q <= from_ptr_d;
              state_q    <= MEM_REQ;
            end
          end
        end
        MEM_REQ: begin
          if (mem_req_ready_i) state_q <= MEM_WAIT;
        end
        MEM_WAIT: begin
          if (mem_rsp_valid_i) begin
            data_q  <= mem_rsp_data_i;
            state_q <= WRITE;
          end
        end
        WRITE: begin
          // Filling an invalid way leaves the pointer alone so it keeps
          // tracking only true replacements.
          if (from_ptr_q) rr_q[set_q] <= rr_q[set_q] + WayWidth'(1);
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // All outputs are decodes of registered state, zeroed outside their phase.
  assign req_ready_o      = (state_q == IDLE);
  assign busy_o           = (state_q != IDLE);
  assign mem_req_valid_o  = (state_q == MEM_REQ);
  assign mem_req_addr_o   = mem_req_valid_o ? {tag_q, set_q} : '0;
  assign mem_rsp_ready_o  = (state_q == MEM_WAIT);
  assign write_en_o       = (state_q == WRITE);
  assign write_set_o      = write_en_o ? set_q : '0;
  assign write_data_way_o = write_en_o ? victim_q : '0;
  assign write_data_o     = write_en_o ? data_q : '0;
  assign done_o           = hit_done_q | write_en_o;
  assign done_miss_o      = write_en_o;

  always_comb begin
    write_info_o = '0;
    if (write_en_o) begin
      write_info_o                 = info_q;
      write_info_o[victim_q].valid = 1'b1;
      write_info_o[victim_q].tag   = tag_q;
    end
  end

endmodule
